// File: rtl/sprite_row_fetcher.sv
// Sprite row fetcher: walks the sprite table at each scanline start, reads one
// ROM row per overlapping sprite, then turns the buffered rows into pixel flags.
module sprite_row_fetcher #(
  parameter int NUM_SLOTS = 4,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          line_start,
  input  logic [9:0]    next_line,
  input  logic [9:0]    hpos,
  input  logic          wr_en,
  input  logic [SW-1:0] wr_slot,
  input  logic [9:0]    wr_x,
  input  logic [9:0]    wr_y,
  input  logic [3:0]    wr_charc,
  input  logic [1:0]    wr_dir,
  input  logic          wr_visible,
  output logic [3:0]    rom_charc,
  output logic [1:0]    rom_direction,
  output logic [2:0]    rom_index,
  input  logic [7:0]    rom_data,
  output logic          fetch_busy,
  output logic          pixel_on,
  output logic [SW-1:0] pixel_slot
);

  typedef enum logic [1:0] {IDLE, SCAN, CAPTURE} state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] charc;
    logic [1:0] dir;
    logic       visible;
  } sprite_t;

  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_SLOTS - 1);

  state_e          state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [9:0]      line_q, line_d;
  sprite_t         tbl_q [NUM_SLOTS];
  sprite_t         tbl_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] active_q, active_d;
  logic [7:0]      rowbuf_q [NUM_SLOTS];
  logic [7:0]      rowbuf_d [NUM_SLOTS];
  logic [3:0]      rom_charc_q, rom_charc_d;
  logic [1:0]      rom_direction_q, rom_direction_d;
  logic [2:0]      rom_index_q, rom_index_d;
  logic            fetch_busy_q, fetch_busy_d;
  logic            pixel_on_q, pixel_on_d;
  logic [SW-1:0]   pixel_slot_q, pixel_slot_d;

  logic [10:0]     dy;
  logic            hit;

  // Table writes land regardless of fetch state; an in-flight SCAN has already
  // read the old fields, so the new ones apply from the next line on.
  always_comb begin
    tbl_d = tbl_q;
    if (wr_en && (int'(wr_slot) < NUM_SLOTS)) begin
      tbl_d[wr_slot] = '{x: wr_x, y: wr_y, charc: wr_charc, dir: wr_dir,
                         visible: wr_visible};
    end
  end

  // Vertical hit test in 11 bits so a sprite above the line never aliases.
  always_comb begin
    dy  = {1'b0, line_q} - {1'b0, tbl_q[slot_q].y};
    hit = tbl_q[slot_q].visible && (line_q >= tbl_q[slot_q].y) && (dy < 11'd8);
  end

  // NOTE: every signal assigned here gets a hold/default value first, so no
  // path through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    slot_d          = slot_q;
    line_d          = line_q;
    active_d        = active_q;
    rowbuf_d        = rowbuf_q;
    rom_charc_d     = rom_charc_q;
    rom_direction_d = rom_direction_q;
    rom_index_d     = rom_index_q;
    if (line_start) begin
      line_d  = next_line;
      slot_d  = '0;
      state_d = SCAN;
    end else begin
      unique case (state_q)
        SCAN: begin
          if (hit) begin
            rom_charc_d     = tbl_q[slot_q].charc;
            rom_direction_d = tbl_q[slot_q].dir;
            rom_index_d     = dy[2:0];
            state_d         = CAPTURE;
          end else begin
            active_d[slot_q] = 1'b0;
            if (slot_q == LAST_SLOT) state_d = IDLE;
            else                     slot_d  = slot_q + SW'(1);
          end
        end
        CAPTURE: begin
          rowbuf_d[slot_q] = rom_data;
          active_d[slot_q] = 1'b1;
          if (slot_q == LAST_SLOT) begin
            state_d = IDLE;
          end else begin
            slot_d  = slot_q + SW'(1);
            state_d = SCAN;
          end
        end
        default: ;
      endcase
    end
    fetch_busy_d = (state_d != IDLE);
  end

  // Descending walk so the lowest-numbered opaque slot wins.
  always_comb begin
    logic [10:0] col;
    col          = '0;
    pixel_on_d   = 1'b0;
    pixel_slot_d = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      col = {1'b0, hpos} - {1'b0, tbl_q[s].x};
      if (active_q[s] && (hpos >= tbl_q[s].x) && (col < 11'd8) &&
          !rowbuf_q[s][3'd7 - col[2:0]]) begin
        pixel_on_d   = 1'b1;
        pixel_slot_d = SW'(s);
      end
    end
  end

  // NOTE: the sprite table and row buffers are reset too; their reset values
  // decide what the first line shows, so they are state, not scratch memory.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      slot_q          <= '0;
      line_q          <= '0;
      active_q        <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        tbl_q[i]    <= '0;
        rowbuf_q[i] <= 8'hFF;
      end
      rom_charc_q     <= 4'hF;
      rom_direction_q <= '0;
      rom_index_q     <= '0;
      fetch_busy_q    <= 1'b0;
      pixel_on_q      <= 1'b0;
      pixel_slot_q    <= '0;
    end else begin
      state_q         <= state_d;
      slot_q          <= slot_d;
      line_q          <= line_d;
      active_q        <= active_d;
      tbl_q           <= tbl_d;
      rowbuf_q        <= rowbuf_d;
      rom_charc_q     <= rom_charc_d;
      rom_direction_q <= rom_direction_d;
      rom_index_q     <= rom_index_d;
      fetch_busy_q    <= fetch_busy_d;
      pixel_on_q      <= pixel_on_d;
      pixel_slot_q    <= pixel_slot_d;
    end
  end

  assign rom_charc     = rom_charc_q;
  assign rom_direction = rom_direction_q;
  assign rom_index     = rom_index_q;
  assign fetch_busy    = fetch_busy_q;
  assign pixel_on      = pixel_on_q;
  assign pixel_slot    = pixel_slot_q;

endmodule

// File: doc/sprite_row_fetcher.md
# sprite_row_fetcher

Downstream sprite stage that drives the 8x8 asset ROM and turns its row data into per-pixel sprite output. When a scanline starts, the block walks a small sprite table. For each visible sprite that overlaps the next line, it issues one ROM row read and latches the 8-bit row into a per-slot shift source. During the active line it compares the beam position against each sprite's x and emits an opaque/transparent pixel flag plus the winning slot, for the colour mixer.

## Interface
Parameters:
- NUM_SLOTS, 4, sprite table entries (1..8); slot index width SW = clog2 (minimum 1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- line_start  in  1  one-cycle pulse at start of horizontal blank; begins fetch for next_line
- next_line  in  10  scanline the fetch targets; sampled on line_start
- hpos  in  10  current horizontal pixel position
- wr_en  in  1  sprite table write strobe
- wr_slot  in  SW  slot to write
- wr_x, wr_y  in  10 each  sprite top-left pixel coordinates
- wr_charc  in  4  asset code
- wr_dir  in  2  orientation (0 up, 1 right, 2 down, 3 left)
- wr_visible  in  1  slot enable
- rom_charc  out  4  ROM asset select (registered)
- rom_direction  out  2  ROM orientation (registered)
- rom_index  out  3  ROM row index (registered)
- rom_data  in  8  combinational ROM row; 0 bit = opaque, MSB = leftmost pixel
- fetch_busy  out  1  high while the fetch FSM is not IDLE
- pixel_on  out  1  an opaque sprite pixel is at the previous cycle's hpos
- pixel_slot  out  SW  lowest-numbered slot producing that pixel

## Operation
- Sprite table: registers per slot. wr_en writes all fields of wr_slot on the clock edge. Writes are always accepted. A write to the slot currently being fetched affects only later lines.
- Line latch: line_start captures next_line into line_q.
- Hit test (11-bit unsigned): hit = visible && line_q >= y && line_q - y < 8; row = (line_q - y)[2:0]. There is no vertical wrap.
- FSM:
  - IDLE: on line_start, slot := 0, go to SCAN.
  - SCAN: evaluate the hit for the current slot.
    - On hit: load rom_charc/rom_direction/rom_index with charc/dir/row, then go to CAPTURE.
    - On miss: clear active[slot]. If this is the last slot go to IDLE, else slot+1 and stay in SCAN.
  - CAPTURE: rowbuf[slot] := rom_data, active[slot] := 1. If this is the last slot go to IDLE, else slot+1 and go to SCAN.
- line_start in any non-IDLE state restarts the fetch: line_q reloaded, slot := 0, state SCAN. Already-fetched rows are left as is and get refetched.
- Pixel stage: col = hpos - x (11-bit). Slot s is covering when active[s] && hpos >= x && col < 8. It is opaque when rowbuf[s][7 - col[2:0]] == 0. There is no horizontal wrap; a sprite at x = 1020 shows 4 columns.
- Output: pixel_on is registered as OR(opaque). pixel_slot is registered as the lowest opaque slot, and is 0 when none.
- The block performs no blanking masking; the mixer gates with its own display-enable.

## Timing
- Reset values:
  - state IDLE, slot 0, line_q 0
  - all table fields 0 (visible 0), all active 0, rowbuf all 1s
  - rom_charc 4'hF, rom_direction 0, rom_index 0
  - fetch_busy 0, pixel_on 0, pixel_slot 0
- Reset mid-fetch aborts immediately to the reset values.
- fetch_busy rises in the cycle after line_start and falls when the FSM returns to IDLE.
- Fetch duration = NUM_SLOTS + hits cycles, max 2*NUM_SLOTS. line_start must lead the first active hpos by at least that.
- ROM read: address registered in SCAN; rom_data sampled in the immediately following CAPTURE cycle, so one-cycle ROM turnaround.
- Pixel latency: 1 cycle from hpos to pixel_on/pixel_slot.
- rom_* hold their last value while IDLE.

## Test plan
- Single hit:
  - Setup: slot0 = {x 100, y 50, charc 1 (sword), dir 0, visible}; line_start with next_line 56.
  - Required: rom_index = 6, rom_charc = 1, rowbuf0 = 8'b11000111.
  - Required: sweeping hpos 100..107 gives pixel_on = 0,0,1,1,1,0,0,0 one cycle later.
- Miss boundaries: y = 50 with next_line 49 and with next_line 58 -> no CAPTURE, active0 = 0, fetch_busy high for exactly 4 cycles with NUM_SLOTS = 4.
- Priority: slots 1 and 3 overlap at hpos 200, both opaque -> pixel_slot = 1. Make slot 1 transparent at that column -> pixel_slot = 3.
- Restart: assert line_start again 3 cycles into a 4-hit fetch -> slot restarts at 0. The total busy period after the second pulse is 8 cycles.
- Edge: x = 1020, y = 1020, next_line 1023 -> only hpos 1020..1023 can assert. line_q - y = 3 gives rom_index 3, with no wrap to line 0.
- Reset mid-fetch: deassert reset during CAPTURE -> all outputs at reset values next cycle. After release, fetch_busy stays 0 until line_start.
